rv_arb_mux_reg: RTL and testbench

//  Parametrised N-to-1 datapath mux with per-channel valid/ready, selectable arbitration mode and a registered output.

---
 rtl/rv_mux_pkg.sv | 13 +
 rtl/rv_rr_arbiter.sv | 33 +++
 rtl/rv_arb_mux_reg.sv | 71 +++++++
 tb/tb_rv_arb_mux_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_mux_pkg.sv
// rv_mux_pkg: shared mode encodings and width helper for the arbitrated result mux
package rv_mux_pkg;
    localparam logic [1:0] MUX_MODE_SEL  = 2'd0;
    localparam logic [1:0] MUX_MODE_PRIO = 2'd1;
    localparam logic [1:0] MUX_MODE_RR   = 2'd2;
    localparam logic [1:0] MUX_MODE_RSVD = 2'd3;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: rotating-start arbiter; prio forces the search to start at channel 0
module rv_rr_arbiter
    import rv_mux_pkg::*;
#(
    parameter int N = 3,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             prio,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] start;
    logic             found;
    int               c;
    assign start = prio ? '0 : ptr;
    // first requester found walking start, start+1, ... with an explicit wrap at N
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(start) + k) % N;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = SEL_W'(c);
            end
        end
    end
endmodule

// File: rtl/rv_arb_mux_reg.sv
// rv_arb_mux_reg: N-to-1 valid/ready mux with selectable arbitration and a registered output
module rv_arb_mux_reg
    import rv_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N = 3,
    localparam int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               sel_err
);
    logic [N-1:0]     arb_gnt;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] arb_idx;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] ptr;
    logic             sel_ok;
    logic             can_load;
    logic             xfer;
    logic             err;

    rv_rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .prio  (mode == MUX_MODE_PRIO),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

    assign sel_ok   = int'(sel) < N;
    assign can_load = !out_valid || out_ready;
    assign err      = (mode == MUX_MODE_RSVD) || (mode == MUX_MODE_SEL && !sel_ok);
    assign in_ready = grant & {N{can_load && rst_n}};
    assign xfer     = |in_ready;

    // forced select bypasses the arbiter; reserved mode and out-of-range sel grant nothing
    always_comb begin
        grant = (mode == MUX_MODE_SEL) ? ((sel_ok && in_valid[sel]) ? N'(1) << sel : '0) :
                (mode == MUX_MODE_PRIO || mode == MUX_MODE_RR) ? arb_gnt : '0;
        gidx  = (mode == MUX_MODE_SEL && sel_ok) ? sel : arb_idx;
    end

    // output register, error pulse and round-robin pointer (advanced only by RR transfers)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            ptr       <= '0;
        end else begin
            sel_err <= err;
            if (can_load) out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[gidx*WIDTH +: WIDTH];
                out_ch   <= gidx;
                if (mode == MUX_MODE_RR) ptr <= (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rv_arb_mux_reg.sv
// tb_rv_arb_mux_reg: vector table, corner sequences and randomized model check for rv_arb_mux_reg
module tb_rv_arb_mux_reg;
    localparam int W = 32;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]     mode;
    logic [1:0]     sel;
    logic [N-1:0]   in_valid, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_ready, sel_err;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;

    logic [1:0]  mode5;
    logic [2:0]  sel5;
    logic [4:0]  v5, r5;
    logic [39:0] d5;
    logic        ov5, ordy5, err5;
    logic [7:0]  od5;
    logic [2:0]  oc5;

    rv_arb_mux_reg #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .sel_err(sel_err)
    );

    rv_arb_mux_reg #(.WIDTH(8), .N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .in_valid(v5),
        .in_ready(r5), .in_data(d5), .out_valid(ov5), .out_ready(ordy5),
        .out_data(od5), .out_ch(oc5), .sel_err(err5)
    );

    int pass = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] sel;
        logic [2:0] v;
        logic       ordy;
        logic [2:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s, input logic [2:0] v,
                                input logic o, input logic [2:0] r, input logic ov,
                                input logic [1:0] ch, input logic e);
        vec_t t;
        t.mode = m; t.sel = s; t.v = v; t.ordy = o; t.rdy = r; t.ov = ov; t.ch = ch; t.err = e;
        return t;
    endfunction

    function automatic int pick(input int m, input int s, input logic [2:0] v, input int p);
        if (m == 0) return (s < N && v[s]) ? s : -1;
        if (m == 1) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
            return -1;
        end
        if (m == 2) begin
            for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
            return -1;
        end
        return -1;
    endfunction

    int        mptr, mc, p;
    bit        mv, merr, cl;
    logic [W-1:0] md;

    initial begin
        mode = 2'd0; sel = 2'd0; in_valid = '0; out_ready = 1'b1;
        in_data = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        mode5 = 2'd1; sel5 = 3'd0; v5 = '0; ordy5 = 1'b1;
        d5 = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};

        tbl.push_back(mk(2'd0, 2'd2, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0));
        tbl.push_back(mk(2'd0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(2'd0, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(2'd3, 2'd0, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 1'b1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(2'd2, 2'd0, 3'b111, 1'b1, 3'(1 << (i % 3)), 1'b1, 2'(i % 3), 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'd1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(2'd2, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0));
        tbl.push_back(mk(2'd0, 2'd2, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'd1, 2'd0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd2, 1'b0));
        tbl.push_back(mk(2'd1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(2'd1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(2'd2, 2'd0, 3'b011, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].v; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("vec%0d_sel_err", i), sel_err, tbl[i].err);
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_out_ch", i), out_ch, tbl[i].ch);
                chk($sformatf("vec%0d_out_data", i), out_data, 32'hCAFE0000 + 32'(tbl[i].ch));
            end
        end

        mode = 2'd1; in_valid = 3'b111; out_ready = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_out_ch", out_ch, 0);
        chk("async_rst_in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        mode = 2'd2; out_ready = 1'b1;
        #1;
        chk("rst_ptr_in_ready", in_ready, 3'b001);
        @(posedge clk); #1;
        chk("rst_ptr_out_ch", out_ch, 0);

        mode5 = 2'd2; v5 = 5'b01000;
        #1;
        chk("n5_ready_ch3", r5, 5'b01000);
        @(posedge clk); #1;
        chk("n5_out_ch3", oc5, 3);
        v5 = 5'b10001;
        #1;
        chk("n5_ready_ch4", r5, 5'b10000);
        @(posedge clk); #1;
        chk("n5_out_ch4", oc5, 4);
        chk("n5_out_data4", od5, 8'hA4);
        #1;
        chk("n5_ready_wrap", r5, 5'b00001);
        @(posedge clk); #1;
        chk("n5_out_wrap", oc5, 0);
        chk("n5_out_data0", od5, 8'hA0);
        mode5 = 2'd0; sel5 = 3'd5; v5 = 5'b11111;
        #1;
        chk("n5_sel5_ready", r5, 0);
        @(posedge clk); #1;
        chk("n5_sel5_err", err5, 1);
        chk("n5_sel5_valid", ov5, 0);
        sel5 = 3'd4;
        #1;
        chk("n5_sel4_ready", r5, 5'b10000);
        @(posedge clk); #1;
        chk("n5_sel4_ch", oc5, 4);
        chk("n5_sel4_err", err5, 0);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mptr = 0; mv = 0; merr = 0; md = '0; mc = 0;
        for (int n = 0; n < 400; n++) begin
            mode = 2'($urandom_range(0, 3));
            sel = 2'($urandom_range(0, 3));
            in_valid = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data = {$urandom, $urandom, $urandom};
            #1;
            p = pick(int'(mode), int'(sel), in_valid, mptr);
            cl = !mv || out_ready;
            chk("rnd_in_ready", in_ready, (p >= 0 && cl) ? 3'(1 << p) : 3'b000);
            merr = (mode == 2'd3) || (mode == 2'd0 && sel >= 2'(N));
            if (cl) begin
                if (p >= 0) begin
                    mv = 1; md = in_data[p*W +: W]; mc = p;
                    if (mode == 2'd2) mptr = (p + 1) % N;
                end else mv = 0;
            end
            @(posedge clk); #1;
            chk("rnd_out_valid", out_valid, mv);
            chk("rnd_sel_err", sel_err, merr);
            if (mv) begin
                chk("rnd_out_data", out_data, md);
                chk("rnd_out_ch", out_ch, mc);
            end
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
